// File: rtl/video_sync_gen.sv
// video_sync_gen: 15 kHz raster counters with registered syncs, blanks, blanked RGB and frame interrupt
module video_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 144,
  parameter int V_ACTIVE = 256,
  parameter int V_FP     = 24,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 28,
  parameter int INT_LINE = 280,
  parameter int INT_HPOS = 0,
  parameter int INT_LEN  = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clken,
  input  logic [2:0] ri,
  input  logic [2:0] gi,
  input  logic [2:0] bi,
  output logic [9:0] hc,
  output logic [8:0] vc,
  output logic [2:0] ro,
  output logic [2:0] go,
  output logic [2:0] bo,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       hblank_n,
  output logic       vblank_n,
  output logic       csync_n,
  output logic       int_n,
  output logic       frame_start
);
  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HLAST  = 11'(HTOTAL - 1);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VLAST  = 11'(VTOTAL - 1);
  localparam logic [10:0] IL     = 11'(INT_LINE);
  localparam logic [10:0] IH_BEG = 11'(INT_HPOS);
  localparam logic [10:0] IH_END = 11'(INT_HPOS + INT_LEN);
  if (HTOTAL > 1024 || VTOTAL > 512) begin : g_bad_total
    $error("video_sync_gen: HTOTAL must be <= 1024 and VTOTAL <= 512");
  end
  if (INT_HPOS + INT_LEN > HTOTAL) begin : g_bad_int_h
    $error("video_sync_gen: INT_HPOS+INT_LEN must not exceed HTOTAL");
  end
  if (INT_LINE >= VTOTAL) begin : g_bad_int_v
    $error("video_sync_gen: INT_LINE must be below VTOTAL");
  end
  if (H_SYNC <= 0 || V_SYNC <= 0) begin : g_bad_sync
    $error("video_sync_gen: H_SYNC and V_SYNC must be positive");
  end
  logic [10:0] h, v;
  logic h_last, v_last, hs, vs, act, irq;
  always_comb begin
    h = {1'b0, hc};
    v = {2'b0, vc};
    h_last = h == HLAST;
    v_last = v == VLAST;
    hs = h >= HS_BEG && h < HS_END;
    vs = v >= VS_BEG && v < VS_END;
    act = h < HA && v < VA;
    irq = v == IL && h >= IH_BEG && h < IH_END;
  end
  // Outputs decode the pre-update position, so they trail hc/vc by one tick.
  always_ff @(posedge clk)
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
      ro <= '0;
      go <= '0;
      bo <= '0;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      hblank_n <= 1'b1;
      vblank_n <= 1'b1;
      csync_n <= 1'b1;
      int_n <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= clken && h_last && v_last;
      if (clken) begin
        hc <= h_last ? '0 : hc + 10'd1;
        vc <= h_last ? (v_last ? '0 : vc + 9'd1) : vc;
        hsync_n <= !hs;
        vsync_n <= !vs;
        hblank_n <= h < HA;
        vblank_n <= v < VA;
        csync_n <= !(hs ^ vs);
        int_n <= !irq;
        ro <= act ? ri : '0;
        go <= act ? gi : '0;
        bo <= act ? bi : '0;
      end
    end
endmodule

// File: tb/tb_video_sync_gen.sv
// tb_video_sync_gen: directed checks on a full-size instance and a shrunken-raster instance
module tb_video_sync_gen;
  logic clk = 1'b0;
  logic rst_a, rst_b, clken, sel;
  logic [2:0] ri, gi, bi;
  logic [9:0] hc_a, hc_b, hc;
  logic [8:0] vc_a, vc_b, vc;
  logic [2:0] ro_a, go_a, bo_a, ro_b, go_b, bo_b;
  logic hs_a, vs_a, hb_a, vb_a, cs_a, in_a, fs_a;
  logic hs_b, vs_b, hb_b, vb_b, cs_b, in_b, fs_b;
  logic [8:0] rgb;
  logic [5:0] nv;
  logic fs;
  int checks, errors;
  int n_hs, n_vs, n_hb, n_vb, n_cs, n_int, n_act, n_zero, n_fs, n_cs_vs;
  int hs_fall, hs_rise, hb_fall, vs_fall, vs_rise, int_fall;
  always #5 clk = ~clk;
  video_sync_gen dut_a (
    .clk(clk), .rst_n(rst_a), .clken(clken), .ri(ri), .gi(gi), .bi(bi),
    .hc(hc_a), .vc(vc_a), .ro(ro_a), .go(go_a), .bo(bo_a),
    .hsync_n(hs_a), .vsync_n(vs_a), .hblank_n(hb_a), .vblank_n(vb_a),
    .csync_n(cs_a), .int_n(in_a), .frame_start(fs_a)
  );
  video_sync_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .INT_LINE(10), .INT_HPOS(2), .INT_LEN(5)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .clken(clken), .ri(ri), .gi(gi), .bi(bi),
    .hc(hc_b), .vc(vc_b), .ro(ro_b), .go(go_b), .bo(bo_b),
    .hsync_n(hs_b), .vsync_n(vs_b), .hblank_n(hb_b), .vblank_n(vb_b),
    .csync_n(cs_b), .int_n(in_b), .frame_start(fs_b)
  );
  assign hc = sel ? hc_b : hc_a;
  assign vc = sel ? vc_b : vc_a;
  assign rgb = sel ? {ro_b, go_b, bo_b} : {ro_a, go_a, bo_a};
  assign nv = sel ? {hs_b, vs_b, hb_b, vb_b, cs_b, in_b} : {hs_a, vs_a, hb_a, vb_a, cs_a, in_a};
  assign fs = sel ? fs_b : fs_a;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_to(input int h, input int v);
    int n;
    n = 0;
    while ((hc != h || vc != v) && n < 20000) begin
      step(1);
      n++;
    end
    chk("wait_pos", vc * 1024 + hc, v * 1024 + h);
  endtask
  // Samples n consecutive ticks, tallying low outputs and first edge positions (vc*1024+hc).
  task automatic scan(input int n);
    logic p_hs, p_vs, p_hb, p_int;
    int pos;
    {n_hs, n_vs, n_hb, n_vb, n_cs, n_int, n_act, n_zero, n_fs, n_cs_vs} = '0;
    {hs_fall, hs_rise, hb_fall, vs_fall, vs_rise, int_fall} = {6{-1}};
    {p_hs, p_vs, p_hb, p_int} = 4'hf;
    for (int i = 0; i < n; i++) begin
      pos = vc * 1024 + hc;
      n_hs += int'(!nv[5]);
      n_vs += int'(!nv[4]);
      n_hb += int'(!nv[3]);
      n_vb += int'(!nv[2]);
      n_cs += int'(!nv[1]);
      n_int += int'(!nv[0]);
      n_act += int'(rgb == 9'o753);
      n_zero += int'(rgb == 9'o000);
      n_fs += int'(fs);
      n_cs_vs += int'(!nv[4] && nv[1]);
      if (!nv[5] && p_hs && hs_fall < 0) hs_fall = pos;
      if (nv[5] && !p_hs && hs_rise < 0) hs_rise = pos;
      if (!nv[4] && p_vs && vs_fall < 0) vs_fall = pos;
      if (nv[4] && !p_vs && vs_rise < 0) vs_rise = pos;
      if (!nv[3] && p_hb && hb_fall < 0) hb_fall = pos;
      if (!nv[0] && p_int && int_fall < 0) int_fall = pos;
      {p_hs, p_vs, p_hb, p_int} = {nv[5], nv[4], nv[3], nv[0]};
      step(1);
    end
  endtask
  initial begin
    int fs_hi;
    checks = 0;
    errors = 0;
    sel = 1'b0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    clken = 1'b1;
    {ri, gi, bi} = 9'o753;
    step(3);
    chk("rst_hc", hc, 0);
    chk("rst_vc", vc, 0);
    chk("rst_flags_n", nv, 6'h3f);
    chk("rst_rgb", rgb, 0);
    chk("rst_fs", fs, 0);
    rst_a = 1'b1;
    step(1);
    chk("rel_hc", hc, 1);
    chk("rel_vc", vc, 0);
    chk("rel_rgb", rgb, 9'o753);
    wait_to(1, 5);
    scan(896);
    chk("a_hs_cnt", n_hs, 64);
    chk("a_hs_fall", hs_fall, 5 * 1024 + 689);
    chk("a_hs_rise", hs_rise, 5 * 1024 + 753);
    chk("a_cs_cnt", n_cs, 64);
    chk("a_hb_cnt", n_hb, 256);
    chk("a_hb_fall", hb_fall, 5 * 1024 + 641);
    chk("a_rgb_act", n_act, 640);
    chk("a_rgb_zero", n_zero, 256);
    chk("a_vs_vb_int_fs", n_vs + n_vb + n_int + n_fs, 0);
    chk("a_hb_back", nv[3], 1);
    wait_to(895, 10);
    step(1);
    chk("a_line_wrap", vc * 1024 + hc, 11 * 1024);
    for (int i = 0; i < 20; i++) begin
      clken = (i % 2 == 0);
      step(1);
      if (i == 1) chk("a_hold_hc", hc, 1);
    end
    chk("a_gated_hc", hc, 10);
    clken = 1'b0;
    step(3);
    chk("a_frozen_hc", hc, 10);
    chk("a_frozen_rgb", rgb, 9'o753);
    clken = 1'b1;
    wait_to(300, 11);
    rst_a = 1'b0;
    clken = 1'b0;
    step(1);
    chk("mid_rst_pos", vc * 1024 + hc, 0);
    chk("mid_rst_flags_n", nv, 6'h3f);
    chk("mid_rst_rgb", rgb, 0);
    rst_a = 1'b1;
    clken = 1'b1;
    step(1);
    chk("mid_rel_pos", vc * 1024 + hc, 1);
    sel = 1'b1;
    rst_a = 1'b0;
    chk("b_rst_flags_n", nv, 6'h3f);
    rst_b = 1'b1;
    step(1);
    chk("b_rel_hc", hc, 1);
    wait_to(31, 15);
    chk("b_fs_before", fs, 0);
    step(1);
    chk("b_frame_wrap", vc * 1024 + hc, 0);
    chk("b_fs_pulse", fs, 1);
    step(1);
    chk("b_fs_after", fs, 0);
    scan(512);
    chk("b_vs_cnt", n_vs, 96);
    chk("b_vs_fall", vs_fall, 10 * 1024 + 1);
    chk("b_vs_rise", vs_rise, 13 * 1024 + 1);
    chk("b_cs_cnt", n_cs, 156);
    chk("b_cs_hi_in_vs", n_cs_vs, 18);
    chk("b_hs_cnt", n_hs, 96);
    chk("b_int_cnt", n_int, 5);
    chk("b_int_fall", int_fall, 10 * 1024 + 3);
    chk("b_hb_cnt", n_hb, 256);
    chk("b_vb_cnt", n_vb, 256);
    chk("b_rgb_act", n_act, 128);
    chk("b_rgb_zero", n_zero, 384);
    chk("b_fs_cnt", n_fs, 1);
    wait_to(29, 15);
    fs_hi = 0;
    for (int i = 0; i < 8; i++) begin
      clken = (i % 2 == 0);
      step(1);
      fs_hi += int'(fs);
      if (i == 1) chk("b_hold_hc", hc, 30);
    end
    chk("b_gated_fs_width", fs_hi, 1);
    chk("b_gated_pos", vc * 1024 + hc, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
- 15 kHz video timing generator that sits directly upstream of the VGA scandoubler.
- Produces raster counters for the pixel/attribute fetch logic, plus registered active-low hsync, vsync, hblank, vblank and serrated csync, all at the pixel-enable rate.
- Produces blanked 9-bit RGB and the once-per-frame maskable interrupt pulse.
- All outputs are timed so the scandoubler can sample them directly on the same clock enable.

Parameters:
- H_ACTIVE, 640, visible ticks per line
- H_FP, 48, front porch ticks
- H_SYNC, 64, hsync width in ticks
- H_BP, 144, back porch ticks; HTOTAL = sum = 896
- V_ACTIVE, 256, visible lines
- V_FP, 24, front porch lines
- V_SYNC, 4, vsync lines
- V_BP, 28, back porch lines; VTOTAL = sum = 312
- INT_LINE, 280, line on which the interrupt asserts
- INT_HPOS, 0, tick on which the interrupt asserts
- INT_LEN, 128, interrupt width in ticks

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  synchronous reset, active low
- clken  in  1  pixel tick enable; all state advances only when this is 1
- ri, gi, bi  in  3 each  pixel colour for the current hc/vc
- hc  out  10  horizontal counter, 0..HTOTAL-1
- vc  out  9  vertical counter, 0..VTOTAL-1
- ro, go, bo  out  3 each  blanked colour, registered
- hsync_n, vsync_n  out  1 each  active-low syncs
- hblank_n, vblank_n  out  1 each  active-low blanks
- csync_n  out  1  composite sync, active low
- int_n  out  1  CPU interrupt, active low
- frame_start  out  1  one-clk pulse at the start of the raster

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous, active low, and has priority over clken.
- Reset values: hc=0, vc=0, ro/go/bo=0, hsync_n=vsync_n=hblank_n=vblank_n=csync_n=int_n=1, frame_start=0.
- Deassertion: rst_n deasserting mid-frame restarts the raster at 0,0 on the next clken. No partial-line state survives.
- Counters, on clk with clken=1:
  - hc = hc+1.
  - If hc==HTOTAL-1: hc=0, and vc = (vc==VTOTAL-1) ? 0 : vc+1.
- clken=0: every register, including frame_start, holds or clears as defined below. Outputs are otherwise frozen.
- Output registers: all sync, blank, colour and interrupt outputs are decoded from the current hc/vc and registered on the same clken. They therefore lag hc/vc by exactly one clken tick. rgb for position (hc,vc) must be presented while hc/vc show that position.
- Decode, using pre-register hc/vc:
  - hblank_n = 0 iff hc >= H_ACTIVE.
  - vblank_n = 0 iff vc >= V_ACTIVE.
  - hsync_n = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync_n = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC. vsync spans whole lines, starting on the tick where hc=0.
  - csync_n = hsync_n decode outside vsync lines; the inverse of the hsync decode inside vsync lines (serrated broad pulses).
  - ro/go/bo = ri/gi/bi when hblank and vblank are both inactive, else 0.
  - int_n = 0 iff vc==INT_LINE and INT_HPOS <= hc < INT_HPOS+INT_LEN.
- frame_start: 1 for exactly one clk cycle, on the clk where clken=1 and hc/vc roll from (HTOTAL-1, VTOTAL-1) to (0,0). It is 0 in every other cycle, including cycles where clken=0.
- Width rules: compare in 11-bit unsigned arithmetic so sums of parameters cannot overflow.
- Parameter constraints, enforced by elaboration-time checks:
  - HTOTAL <= 1024 and VTOTAL <= 512.
  - INT_HPOS+INT_LEN <= HTOTAL.
  - INT_LINE < VTOTAL.
  - H_SYNC > 0 and V_SYNC > 0.
- Boundary cases:
  - hsync is decoded on every line, including vblank lines.
  - int_n overlapping vsync lines is legal and independent of it.
  - clken held high every cycle is legal; the block then runs at clk rate.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with clken=1 → hc=0, vc=0, all *_n=1, ro/go/bo=0, frame_start=0. Release → hc=1 after the first clken.
- Line wrap: run to hc=895, vc=10 → next clken gives hc=0, vc=11. hblank_n goes 0 one tick after hc reaches 640 and returns to 1 one tick after hc=0.
- Hsync edges: on vc=5, hsync_n and csync_n fall one tick after hc=688 and rise one tick after hc=752, giving exactly 64 ticks low.
- Frame wrap and vsync:
  - At hc=895, vc=311, the next clken gives 0,0 and frame_start=1 for one clk.
  - vsync_n is low for vc 280..283 (4×896 ticks).
  - On those lines csync_n is high only during ticks 688..751.
- Interrupt and blanking:
  - Drive ri=gi=bi=7 → int_n is low for 128 ticks starting one tick after (hc=0, vc=280).
  - ro=7 for vc<256, hc<640; ro=0 elsewhere.
- Enable gating and mid-frame reset:
  - clken toggling 1/0 → counters advance only on enabled cycles, and frame_start is never wider than one clk.
  - Assert rst_n=0 at hc=300, vc=150 → reset values on the next clk.
